// File: rtl/digit_frame_display_if.sv
// Bus between the digit generator side and the frame display block.
// The generator (or bench) drives the digit stream; the display block drives the outputs.
interface digit_frame_display_if #(
   parameter int NUM_DIGITS = 10
);
   logic [3:0]            digit_in;
   logic                  digit_valid;
   logic                  frame_clr;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] an;
   logic                  frame_done;
   logic [7:0]            frame_cnt;
   logic                  digit_err;

   modport master (
      output digit_in, digit_valid, frame_clr,
      input  seg, an, frame_done, frame_cnt, digit_err
   );

   modport slave (
      input  digit_in, digit_valid, frame_clr,
      output seg, an, frame_done, frame_cnt, digit_err
   );
endinterface

// File: rtl/digit_frame_display.sv
// Collects BCD digits into frames, double-buffers each completed frame and
// scans the stable frame onto a multiplexed 7-segment display.
module digit_frame_display #(
   parameter int NUM_DIGITS     = 10,
   parameter int SCAN_DIV       = 4,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   digit_frame_display_if.slave  bus
);
   localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DIGITS - 1);
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
   localparam logic             POL      = (SEG_ACTIVE_LOW != 0);

   logic [3:0]            fill_buf [NUM_DIGITS];
   logic [3:0]            disp_buf [NUM_DIGITS];
   logic [PTR_W-1:0]      wr_ptr;
   logic                  disp_valid;
   logic                  frame_done_q;
   logic [7:0]            frame_cnt_q;
   logic                  digit_err_q;
   logic [PS_W-1:0]       prescale;
   logic [PTR_W-1:0]      scan_idx;
   logic [6:0]            seg_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic                  capture;
   logic                  last_digit;

   // A digit is taken only when no abort is pending; frame_clr has priority.
   assign capture    = bus.digit_valid && !bus.frame_clr;
   assign last_digit = (wr_ptr == PTR_LAST);

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // Write pointer, frame completion, frame counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         disp_valid   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         digit_err_q  <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (bus.frame_clr) begin
            wr_ptr      <= '0;
            digit_err_q <= 1'b0;
         end else if (bus.digit_valid) begin
            if (bus.digit_in > 4'd9) begin
               digit_err_q <= 1'b1;
            end
            if (last_digit) begin
               wr_ptr       <= '0;
               disp_valid   <= 1'b1;
               frame_done_q <= 1'b1;
               frame_cnt_q  <= frame_cnt_q + 8'd1;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
      end
   end

   // Digit storage; the last digit bypasses fill_buf straight into disp_buf.
   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         fill_buf[wr_ptr] <= bus.digit_in;
         if (last_digit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               disp_buf[i] <= (i == NUM_DIGITS - 1) ? bus.digit_in : fill_buf[i];
            end
         end
      end
   end

   // Free-running scan: prescale divides clk, scan_idx walks the positions.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescale <= '0;
         scan_idx <= '0;
      end else if (prescale == PS_LAST) begin
         prescale <= '0;
         scan_idx <= (scan_idx == PTR_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   // Registered segment/anode drive, blank until the first frame is loaded.
   always_ff @(posedge clk) begin
      if (rst || !disp_valid) begin
         seg_q <= {7{POL}};
         an_q  <= {NUM_DIGITS{POL}};
      end else begin
         seg_q <= seg_decode(disp_buf[scan_idx]) ^ {7{POL}};
         an_q  <= (NUM_DIGITS'(1) << scan_idx) ^ {NUM_DIGITS{POL}};
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.digit_err  = digit_err_q;
endmodule

// File: tb/tb_digit_frame_display.sv
// Bench for digit_frame_display: directed vector tables, corner sequences and
// randomized traffic, all checked against a frame/scan reference model.
module tb_digit_frame_display;
   localparam int N  = 10;
   localparam int SD = 4;
   localparam bit AL = 1'b1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   digit_frame_display_if #(.NUM_DIGITS(N)) bus ();

   digit_frame_display #(
      .NUM_DIGITS(N),
      .SCAN_DIV(SD),
      .SEG_ACTIVE_LOW(int'(AL))
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int fd_seen = 0;

   // reference model state
   int             q[$];
   int             disp[N];
   bit             m_dv;
   int             m_fcnt;
   bit             m_err;
   bit             m_fd;
   int             k;
   logic [6:0]     m_seg;
   logic [N-1:0]   m_an;

   logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

   function automatic logic [6:0] dec(int d);
      return (d >= 0 && d <= 9) ? seg_tab[d] : 7'b0000000;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, compare every output.
   task automatic step(bit r, bit v, int d, bit c);
      @(negedge clk);
      rst             = r;
      bus.digit_valid = v;
      bus.digit_in    = 4'(d);
      bus.frame_clr   = c;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_dv   = 1'b0;
         m_fcnt = 0;
         m_err  = 1'b0;
         m_fd   = 1'b0;
         k      = 0;
         m_seg  = AL ? 7'h7f : 7'h00;
         m_an   = AL ? '1 : '0;
      end else begin
         if (m_dv) begin
            int idx;
            idx   = (k / SD) % N;
            m_seg = dec(disp[idx]);
            m_an  = N'(1) << idx;
         end else begin
            m_seg = 7'h00;
            m_an  = '0;
         end
         if (AL) begin
            m_seg = ~m_seg;
            m_an  = ~m_an;
         end
         m_fd = 1'b0;
         if (c) begin
            q.delete();
            m_err = 1'b0;
         end else if (v) begin
            if (d > 9) m_err = 1'b1;
            q.push_back(d);
            if (q.size() == N) begin
               for (int i = 0; i < N; i++) disp[i] = q[i];
               m_dv   = 1'b1;
               m_fcnt = (m_fcnt + 1) % 256;
               m_fd   = 1'b1;
               q.delete();
            end
         end
         k++;
      end
      #1;
      chk("seg", 32'(bus.seg), 32'(m_seg));
      chk("an", 32'(bus.an), 32'(m_an));
      chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fcnt));
      chk("digit_err", 32'(bus.digit_err), 32'(m_err));
      if (bus.frame_done === 1'b1) fd_seen++;
   endtask

   // Idle until position p is lit, then check its segments against a literal.
   task automatic wait_pos(int p, logic [6:0] exp_seg, string name);
      logic [N-1:0] want;
      bit found;
      want  = AL ? ~(N'(1) << p) : (N'(1) << p);
      found = 1'b0;
      for (int i = 0; i < 4 * N * SD && !found; i++) begin
         step(0, 0, 0, 0);
         if (bus.an === want) begin
            found = 1'b1;
            chk(name, 32'(bus.seg), 32'(exp_seg));
         end
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: position %0d never selected, an=%b", name, p, bus.an);
      end
   endtask

   typedef struct {
      bit r;
      bit v;
      int d;
      bit c;
      bit fd;
      int fcnt;
      bit err;
   } vec_t;

   vec_t vt[$];

   task automatic run_vt(string name);
      foreach (vt[i]) begin
         step(vt[i].r, vt[i].v, vt[i].d, vt[i].c);
         chk({name, "_fd"}, 32'(bus.frame_done), 32'(vt[i].fd));
         chk({name, "_fcnt"}, 32'(bus.frame_cnt), 32'(vt[i].fcnt));
         chk({name, "_err"}, 32'(bus.digit_err), 32'(vt[i].err));
      end
      vt.delete();
   endtask

   initial begin
      rst             = 1'b1;
      bus.digit_in    = 4'd0;
      bus.digit_valid = 1'b0;
      bus.frame_clr   = 1'b0;

      // blank display before any frame
      step(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0);
         chk("preframe_an", 32'(bus.an), 32'(10'b1111111111));
         chk("preframe_seg", 32'(bus.seg), 32'(7'b1111111));
      end

      // frame 9..0 on consecutive cycles
      vt.push_back('{1, 0, 0, 0, 0, 0, 0});
      for (int d = 9; d >= 0; d--) vt.push_back('{0, 1, d, 0, (d == 0), (d == 0) ? 1 : 0, 0});
      vt.push_back('{0, 0, 0, 0, 0, 1, 0});
      vt.push_back('{0, 0, 0, 0, 0, 1, 0});
      run_vt("frame1");
      wait_pos(0, 7'b0010000, "frame1_pos0_seg");

      // out-of-range digit at position 3
      for (int i = 0; i < N; i++) begin
         int d;
         d = (i == 3) ? 12 : i;
         vt.push_back('{0, 1, d, 0, (i == N - 1), (i == N - 1) ? 2 : 1, (i >= 3)});
      end
      vt.push_back('{0, 0, 0, 0, 0, 2, 1});
      run_vt("err");
      wait_pos(3, 7'b1111111, "err_pos3_blank");
      chk("err_sticky", 32'(bus.digit_err), 32'(1));
      step(0, 0, 0, 1);
      chk("err_cleared", 32'(bus.digit_err), 32'(0));

      // same 9..0 with random idle gaps
      step(1, 0, 0, 0);
      fd_seen = 0;
      for (int d = 9; d >= 0; d--) begin
         step(0, 1, d, 0);
         for (int g = $urandom_range(0, 3); g > 0; g--) step(0, 0, 0, 0);
      end
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      chk("gaps_fd_count", 32'(fd_seen), 32'(1));
      chk("gaps_fcnt", 32'(bus.frame_cnt), 32'(1));
      wait_pos(0, 7'b0010000, "gaps_pos0_seg");

      // partial frame aborted by frame_clr with a simultaneous digit
      for (int i = 0; i < 4; i++) step(0, 1, 5, 0);
      step(0, 1, 7, 1);
      fd_seen = 0;
      for (int d = 1; d <= 10; d++) step(0, 1, d % 10, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      chk("clr_fd_count", 32'(fd_seen), 32'(1));
      chk("clr_fcnt", 32'(bus.frame_cnt), 32'(2));
      wait_pos(0, ~7'b0000110, "clr_pos0_seg");
      wait_pos(9, ~7'b0111111, "clr_pos9_seg");

      // reset mid-frame, two cycles long
      for (int i = 0; i < 6; i++) step(0, 1, i, 0);
      step(1, 0, 0, 0);
      step(1, 1, 3, 0);
      chk("rst_seg", 32'(bus.seg), 32'(7'b1111111));
      chk("rst_an", 32'(bus.an), 32'(10'b1111111111));
      chk("rst_fd", 32'(bus.frame_done), 32'(0));
      chk("rst_fcnt", 32'(bus.frame_cnt), 32'(0));
      chk("rst_err", 32'(bus.digit_err), 32'(0));
      for (int i = 0; i < N; i++) step(0, 1, 9 - i, 0);
      step(0, 0, 0, 0);
      chk("rst_refill_fcnt", 32'(bus.frame_cnt), 32'(1));

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bit r, c, v;
         int d;
         r = ($urandom_range(0, 499) == 0);
         c = ($urandom_range(0, 59) == 0);
         v = ($urandom_range(0, 2) != 0);
         d = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
         step(r, v, d, c);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
